// File: rtl/key_seq_pkg.sv
// key_seq_pkg: shared constants and helpers for the key sequencer.
//   DEBOUNCE_DEFAULT : stable samples needed to accept a key change (20 ms @ 50 MHz)
//   SYNC_DEFAULT     : key_n synchronizer depth
//   cnt_width()      : debounce counter width, ceil(log2(n)), minimum 1
package key_seq_pkg;
  localparam int DEBOUNCE_DEFAULT = 1000000;
  localparam int SYNC_DEFAULT     = 2;

  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/key_sequencer_if.sv
// key_sequencer_if: pushbutton/operand side and evaluator side of the sequencer.
//   key_n, sw_in          : raw inputs (driven by master)
//   go, data_out          : debounced level and latched operand (driven by slave)
//   press_pulse,
//   release_pulse         : one-cycle strobes on accepted edges
//   op_index              : accepted releases modulo 4
interface key_sequencer_if;
  logic       key_n;
  logic [7:0] sw_in;
  logic       go;
  logic [7:0] data_out;
  logic       press_pulse;
  logic       release_pulse;
  logic [1:0] op_index;

  modport master (
    output key_n, sw_in,
    input  go, data_out, press_pulse, release_pulse, op_index
  );

  modport slave (
    input  key_n, sw_in,
    output go, data_out, press_pulse, release_pulse, op_index
  );
endinterface

// File: rtl/sync_chain.sv
// sync_chain: SYNC_STAGES-deep flip-flop synchronizer for the raw key.
//   clk, resetn : clock, synchronous active-low reset
//   d           : asynchronous input
//   q           : synchronized output; resets to 1 (key released)
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (!resetn) chain_q <= '1;
    else         chain_q <= {chain_q[SYNC_STAGES-2:0], d};
  end

  assign q = chain_q[SYNC_STAGES-1];
endmodule

// File: rtl/key_sequencer.sv
// key_sequencer: synchronizes and debounces a pushbutton, latches the switch
// operand on each accepted press and counts accepted releases.
//   clk, resetn : clock, synchronous active-low reset
//   bus         : key_sequencer_if.slave (key_n/sw_in in; go, data_out,
//                 press_pulse, release_pulse, op_index out)
// All outputs are registers; nothing from key_n reaches an output combinationally.
module key_sequencer
  import key_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  key_sequencer_if.slave bus
);
  localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          key_sync, key_s;
  logic          stab_q, stab_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic [1:0]    opi_q, opi_d;
  logic          accept;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (bus.key_n),
    .q      (key_sync)
  );

  assign key_s = ~key_sync;

  // Accept only after DEBOUNCE_CYCLES consecutive differing samples; any
  // sample matching stab clears the count (no partial credit for bounces).
  assign accept = (key_s != stab_q) && (cnt_q == CNT_MAX);

  always_comb begin
    stab_d  = stab_q;
    cnt_d   = '0;
    data_d  = data_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    opi_d   = opi_q;
    if (key_s != stab_q) begin
      if (accept) begin
        stab_d = ~stab_q;
        if (!stab_q) begin
          press_d = 1'b1;
          data_d  = bus.sw_in;
        end else begin
          rel_d = 1'b1;
          opi_d = opi_q + 2'd1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stab_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      opi_q   <= '0;
    end else begin
      stab_q  <= stab_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      opi_q   <= opi_d;
    end
  end

  // go is the stable state itself, so it rises on the same edge data_out loads.
  assign bus.go            = stab_q;
  assign bus.data_out      = data_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.op_index      = opi_q;
endmodule

// File: tb/tb_key_sequencer.sv
// tb_key_sequencer: directed vectors for key_sequencer with DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2, so a clean key edge is accepted on the 6th rising edge.
module tb_key_sequencer;
  logic clk, resetn;
  int   n_cmp, n_bad;
  int   n_press, n_rel, n_both;

  key_sequencer_if bus ();

  key_sequencer #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample #1 later, tally strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.press_pulse)   n_press++;
    if (bus.release_pulse) n_rel++;
    if (bus.press_pulse && bus.release_pulse) n_both++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".go"},   32'(bus.go), 0);
    chk({tag, ".data"}, 32'(bus.data_out), 0);
    chk({tag, ".pp"},   32'(bus.press_pulse), 0);
    chk({tag, ".rp"},   32'(bus.release_pulse), 0);
    chk({tag, ".opi"},  32'(bus.op_index), 0);
  endtask

  // Clean press: go must stay low for 5 edges and rise on the 6th with data.
  task automatic press(input string tag, input logic [7:0] sw);
    int early;
    early = 0;
    bus.sw_in = sw;
    bus.key_n = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6 && (bus.go || bus.press_pulse)) early++;
    end
    chk({tag, ".early"}, 32'(early), 0);
    chk({tag, ".go"},    32'(bus.go), 1);
    chk({tag, ".pp"},    32'(bus.press_pulse), 1);
    chk({tag, ".data"},  32'(bus.data_out), 32'(sw));
    tick();
    chk({tag, ".pp1"},   32'(bus.press_pulse), 0);
  endtask

  task automatic release_key(input string tag, input logic [1:0] exp_opi);
    int early;
    early = 0;
    bus.key_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6 && (!bus.go || bus.release_pulse)) early++;
    end
    chk({tag, ".early"}, 32'(early), 0);
    chk({tag, ".go"},    32'(bus.go), 0);
    chk({tag, ".rp"},    32'(bus.release_pulse), 1);
    chk({tag, ".opi"},   32'(bus.op_index), 32'(exp_opi));
    tick();
    chk({tag, ".rp1"},   32'(bus.release_pulse), 0);
  endtask

  initial begin
    int bad, rel0;
    n_cmp = 0; n_bad = 0; n_press = 0; n_rel = 0; n_both = 0;
    resetn    = 1'b0;
    bus.key_n = 1'b1;
    bus.sw_in = 8'h00;
    repeat (3) tick();
    chk_zero("reset");
    resetn = 1'b1;
    repeat (3) tick();
    chk_zero("idle");

    // Clean press latches 8'h2A; release steps op_index and keeps data.
    press("p2a", 8'h2A);
    repeat (3) tick();
    chk("p2a.hold", 32'(bus.go), 1);
    release_key("r1", 2'd1);
    chk("r1.data", 32'(bus.data_out), 32'h2A);

    // Bounce: low 3, high 1, then low; accept 6 edges after the final fall.
    repeat (3) tick();
    bus.sw_in = 8'h11;
    bus.key_n = 1'b0;
    bad = 0;
    repeat (3) begin tick(); if (bus.go) bad++; end
    bus.key_n = 1'b1;
    tick(); if (bus.go) bad++;
    bus.key_n = 1'b0;
    for (int i = 1; i <= 5; i++) begin tick(); if (bus.go || bus.press_pulse) bad++; end
    chk("bounce.nogo", 32'(bad), 0);
    tick();
    chk("bounce.go",   32'(bus.go), 1);
    chk("bounce.pp",   32'(bus.press_pulse), 1);
    chk("bounce.data", 32'(bus.data_out), 32'h11);

    // Operand change while held must not reach data_out.
    bus.sw_in = 8'h22;
    repeat (4) tick();
    chk("swchg.held", 32'(bus.data_out), 32'h11);
    release_key("r2", 2'd2);
    chk("swchg.rel",  32'(bus.data_out), 32'h11);
    press("p22", 8'h22);
    release_key("r3", 2'd3);

    // Four press/release pairs from reset: op_index 1,2,3,0.
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    chk_zero("rst2");
    n_press = 0;
    for (int k = 0; k < 4; k++) begin
      press("pk", 8'(8'h40 + k));
      release_key("rk", 2'(k + 1));
    end
    chk("pairs.npress", 32'(n_press), 4);

    // Reset 2 counts into an accepted press with key held.
    bus.sw_in = 8'h5C;
    bus.key_n = 1'b0;
    repeat (4) tick();
    rel0 = n_rel;
    resetn = 1'b0;
    tick();
    chk_zero("midrst");
    resetn = 1'b1;
    bad = 0;
    for (int i = 1; i <= 5; i++) begin tick(); if (bus.go || bus.press_pulse) bad++; end
    chk("midrst.nogo", 32'(bad), 0);
    tick();
    chk("midrst.go",   32'(bus.go), 1);
    chk("midrst.data", 32'(bus.data_out), 32'h5C);
    repeat (3) tick();
    chk("midrst.norel", 32'(n_rel - rel0), 0);
    chk("never.both",   32'(n_both), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/key_sequencer.md
KEY_SEQUENCER -- requirements
Module: key_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable synchronized samples required to accept a key change (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter SYNC_STAGES, default 2, depth of the key_n synchronizer; legal range 2..4.
REQ-003 clk  input  1  system clock, CLOCK_50 domain.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 key_n  input  1  raw pushbutton, asynchronous and bouncy, 0 = pressed.
REQ-006 sw_in  input  8  raw switch operand value, quasi-static.
REQ-007 go  output  1  debounced press level, 1 = pressed; drives the evaluator's go.
REQ-008 data_out  output  8  operand latched at accepted press; drives the evaluator's data_in.
REQ-009 press_pulse  output  1  one-cycle strobe on each accepted press.
REQ-010 release_pulse  output  1  one-cycle strobe on each accepted release.
REQ-011 op_index  output  2  count of accepted releases modulo 4, for operand-slot display.

Function
REQ-012 key_n SHALL pass through a SYNC_STAGES flip-flop chain before any other use; the synchronized sample is key_s (1 = pressed after inversion).
REQ-013 The block SHALL hold a registered stable state, stab, and a debounce counter, cnt, sized ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-014 Each cycle with key_s == stab: cnt SHALL clear to 0.
REQ-015 Each cycle with key_s != stab and cnt < DEBOUNCE_CYCLES-1: cnt SHALL increment.
REQ-016 Each cycle with key_s != stab and cnt == DEBOUNCE_CYCLES-1: stab SHALL toggle and cnt SHALL clear to 0.
REQ-017 Any bounce (key_s returning to stab) before acceptance SHALL restart the count from 0; no partial credit.
REQ-018 go SHALL equal stab, registered, with no combinational path from key_n.
REQ-019 Latency: a clean key_n edge SHALL change go on the (SYNC_STAGES + DEBOUNCE_CYCLES)th rising clk edge after the edge.
REQ-020 On the edge where stab changes 0->1: data_out SHALL load sw_in, press_pulse SHALL be 1 for exactly that cycle, and go SHALL rise in the same cycle as data_out updates.
REQ-021 data_out SHALL hold its value while go = 1 and after release, until the next accepted press.
REQ-022 On the edge where stab changes 1->0: release_pulse SHALL be 1 for exactly one cycle, and op_index SHALL increment, wrapping 3->0.
REQ-023 press_pulse and release_pulse SHALL never both be 1 in the same cycle.
REQ-024 Minimum go high or low time SHALL be DEBOUNCE_CYCLES cycles, which guarantees the evaluator sees each level for more than one cycle.

Reset
REQ-025 While resetn = 0 at a clk edge: the synchronizer SHALL load all-released, stab = 0, cnt = 0, go = 0, data_out = 0, press_pulse = 0, release_pulse = 0, op_index = 0.
REQ-026 Reset asserted with the key held SHALL yield go = 0; after reset deasserts, the held key SHALL be accepted as a new press after the full REQ-019 latency.
REQ-027 Reset mid-count SHALL discard the partial count; no pulse SHALL be emitted for the interrupted transition.

Structure
REQ-028 Shared package key_seq_pkg SHALL hold DEBOUNCE_DEFAULT (1000000), SYNC_DEFAULT (2), and the counter-width function.
REQ-029 The synchronizer SHALL be a separate sub-module sync_chain(clk, resetn, d, q), parameterized by SYNC_STAGES, with reset value 1 (released).
REQ-030 No other sub-modules; the counter, stable state and latches reside in key_sequencer.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-031 Stimulus: sw_in=8'h2A, then key_n 1->0 held clean. Required: go rises on the 6th edge, data_out=8'h2A in the same cycle, one press_pulse.
REQ-032 Stimulus: key_n low for 3 cycles, high for 1, then low for 10 cycles. Required: no go during the bounce; go rises 6 edges after the final fall.
REQ-033 Stimulus: four clean press/release pairs. Required: op_index steps 1, 2, 3, 0 on each release_pulse; press_pulse count = 4.
REQ-034 Stimulus: sw_in changes from 8'h11 to 8'h22 while go = 1. Required: data_out stays 8'h11 until the next press.
REQ-035 Stimulus: resetn pulsed low for one cycle, 2 cycles into an accepted press count with key held. Required: all outputs 0 after reset; go rises 6 edges after resetn returns high; no release_pulse.
